mod_counter: RTL and testbench

Parametrised up/down counter with programmable modulo limit, step size, wrap or saturate mode, parallel load, clock-enable prescaler, a terminal-count pulse and sticky overflow/underflow flags. It is the general-purpose successor to the basic 8-bit init/inc/dec counter. It is used wherever a bounded event, timer or address counter is needed.

---
 rtl/mod_counter_pkg.sv | 18 +
 rtl/mod_counter_tick_prescaler.sv | 39 +++
 rtl/mod_counter.sv | 140 ++++++++++++++
 tb/tb_mod_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and default widths for the modulo up/down counter.
package mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_e;

  localparam int unsigned BITS_DEF          = 8;
  localparam int unsigned STEP_BITS_DEF     = 4;
  localparam int unsigned PRESCALE_BITS_DEF = 8;

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// Clock-enable prescaler: strobes o_tick once every i_prescale+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE_BITS = mod_counter_pkg::PRESCALE_BITS_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_enable,
  input  logic [PRESCALE_BITS-1:0] i_prescale,
  output logic                     o_tick
);

  logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
  logic                     tick;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      // >= rather than == so a reload lowered mid-count cannot strand the phase
      if (cnt_q >= i_prescale) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = tick;

endmodule

// File: rtl/mod_counter.sv
// Up/down counter with programmable modulo limit, step, wrap/saturate,
// parallel load, prescaled enable, terminal-count pulse and sticky flags.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned BITS          = BITS_DEF,
  parameter int unsigned STEP_BITS     = STEP_BITS_DEF,
  parameter int unsigned PRESCALE_BITS = PRESCALE_BITS_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_init,
  input  logic                     i_load,
  input  logic [BITS-1:0]          i_load_value,
  input  logic                     i_enable,
  input  logic                     i_inc_dec,
  input  logic [STEP_BITS-1:0]     i_step,
  input  logic [BITS-1:0]          i_limit,
  input  logic                     i_saturate,
  input  logic [PRESCALE_BITS-1:0] i_prescale,
  output logic [BITS-1:0]          o_value,
  output logic                     o_tc,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned W = BITS + 1;

  typedef struct packed {
    logic [BITS-1:0] value;
    logic            tc;
    logic            ovf;
    logic            unf;
  } adv_t;

  // All arithmetic is one bit wider than the count so L = limit+1 never overflows.
  function automatic adv_t next_value(input logic [BITS-1:0]      value,
                                      input dir_e                 dir,
                                      input logic [STEP_BITS-1:0] step,
                                      input logic [BITS-1:0]      limit,
                                      input mode_e                mode);
    adv_t         r;
    logic [W-1:0] v, s, lim, l, sum, res;
    v   = W'(value);
    s   = W'(step);
    lim = W'(limit);
    l   = lim + 1'b1;
    sum = v + s;
    res = v;
    r   = '0;
    if (v > lim) begin
      res   = lim;
      r.ovf = 1'b1;
      r.tc  = 1'b1;
    end else if (s == '0) begin
      res = v;
    end else if (dir == DIR_UP) begin
      if (sum <= lim) begin
        res = sum;
      end else begin
        r.ovf = 1'b1;
        r.tc  = 1'b1;
        if (mode == MODE_SATURATE) res = lim;
        else if (s > l)            res = '0;
        else                       res = sum - l;
      end
    end else begin
      if (v >= s) begin
        res = v - s;
      end else begin
        r.unf = 1'b1;
        r.tc  = 1'b1;
        if (mode == MODE_SATURATE) res = '0;
        else if (s > l)            res = lim;
        else                       res = v + l - s;
      end
    end
    r.value = res[BITS-1:0];
    return r;
  endfunction

  logic            tick;
  adv_t            adv;
  logic [BITS-1:0] value_q, value_d;
  logic            tc_q, tc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  tick_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_init | i_load),
    .i_enable  (i_enable),
    .i_prescale(i_prescale),
    .o_tick    (tick)
  );

  always_comb begin
    adv     = next_value(value_q, dir_e'(i_inc_dec), i_step, i_limit,
                         mode_e'(i_saturate));
    value_d = value_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (i_init) begin
      value_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (i_load) begin
      value_d = i_load_value;
    end else if (tick) begin
      value_d = adv.value;
      tc_d    = adv.tc;
      ovf_d   = ovf_q | adv.ovf;
      unf_d   = unf_q | adv.unf;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_value     = value_q;
  assign o_tc        = tc_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed-vector bench for mod_counter with hand-computed expectations.
module tb_mod_counter;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_init;
  logic       i_load;
  logic [7:0] i_load_value;
  logic       i_enable;
  logic       i_inc_dec;
  logic [3:0] i_step;
  logic [7:0] i_limit;
  logic       i_saturate;
  logic [7:0] i_prescale;
  logic [7:0] o_value;
  logic       o_tc;
  logic       o_overflow;
  logic       o_underflow;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  mod_counter #(
    .BITS(8),
    .STEP_BITS(4),
    .PRESCALE_BITS(8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_init      (i_init),
    .i_load      (i_load),
    .i_load_value(i_load_value),
    .i_enable    (i_enable),
    .i_inc_dec   (i_inc_dec),
    .i_step      (i_step),
    .i_limit     (i_limit),
    .i_saturate  (i_saturate),
    .i_prescale  (i_prescale),
    .o_value     (o_value),
    .o_tc        (o_tc),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    i_load = 1'b1; i_load_value = v;
    cycle();
    i_load = 1'b0;
  endtask

  task automatic clear();
    i_init = 1'b1;
    cycle();
    i_init = 1'b0;
  endtask

  task automatic advance();
    i_enable = 1'b1;
    cycle();
    i_enable = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [7:0] v, input logic tc,
                      input logic ov, input logic un);
    check({tag, ".value"}, o_value, v);
    check({tag, ".tc"}, o_tc, tc);
    check({tag, ".ovf"}, o_overflow, ov);
    check({tag, ".unf"}, o_underflow, un);
  endtask

  initial begin
    i_rst_n = 1'b0; i_init = 1'b0; i_load = 1'b0; i_load_value = '0;
    i_enable = 1'b0; i_inc_dec = 1'b1; i_step = 4'd1; i_limit = 8'd9;
    i_saturate = 1'b0; i_prescale = '0;
    #3;
    outs("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    i_rst_n = 1'b1;

    // Wrap up 0..9 modulo 10
    i_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check($sformatf("wrap_up[%0d].value", i), o_value, 8'(i % 10));
      check($sformatf("wrap_up[%0d].tc", i), o_tc, i == 10);
      check($sformatf("wrap_up[%0d].ovf", i), o_overflow, i >= 10);
    end
    i_enable = 1'b0;
    clear();
    outs("init", 8'd0, 1'b0, 1'b0, 1'b0);

    // Wrap down: 2 - 3 mod 10 = 9
    load(8'd2);
    i_inc_dec = 1'b0; i_step = 4'd3;
    advance();
    outs("wrap_down", 8'd9, 1'b1, 1'b0, 1'b1);
    cycle();
    check("wrap_down.tc_drop", o_tc, 1'b0);

    // Saturate up: 196+7 clamps at 200, repeated advance pulses again
    clear();
    load(8'd196);
    i_limit = 8'd200; i_step = 4'd7; i_inc_dec = 1'b1; i_saturate = 1'b1;
    advance();
    outs("sat_up1", 8'd200, 1'b1, 1'b1, 1'b0);
    advance();
    outs("sat_up2", 8'd200, 1'b1, 1'b1, 1'b0);
    cycle();
    check("sat_up.tc_drop", o_tc, 1'b0);

    // Saturate down: 3-7 clamps at 0
    load(8'd3);
    i_inc_dec = 1'b0;
    advance();
    outs("sat_down", 8'd0, 1'b1, 1'b1, 1'b1);
    i_saturate = 1'b0;

    // Zero step: no change, no pulse
    i_step = 4'd0; i_inc_dec = 1'b1;
    load(8'd5);
    clear();
    load(8'd5);
    advance();
    outs("step0", 8'd5, 1'b0, 1'b0, 1'b0);

    // Full-range limit wraps naturally: 0xFE+3 = 0x01
    i_limit = 8'hFF; i_step = 4'd3;
    load(8'hFE);
    advance();
    outs("full_wrap", 8'h01, 1'b1, 1'b1, 1'b0);

    // Prescaler: advance every 4th enabled cycle, phase held while disabled
    clear();
    i_step = 4'd1; i_prescale = 8'd3; i_enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      check($sformatf("presc[%0d]", i), o_value, 8'(i / 4));
    end
    cycle(); cycle();
    check("presc.pre_pause", o_value, 8'd2);
    i_enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("presc.paused", o_value, 8'd2);
    i_enable = 1'b1;
    cycle();
    check("presc.resume1", o_value, 8'd2);
    cycle();
    check("presc.resume2", o_value, 8'd3);
    i_enable = 1'b0;
    i_prescale = 8'd0;

    // Build both flags, then init+load together with enable high
    i_limit = 8'd9;
    load(8'd9);
    advance();
    outs("flags_ovf", 8'd0, 1'b1, 1'b1, 1'b0);
    i_inc_dec = 1'b0;
    advance();
    outs("flags_unf", 8'd9, 1'b1, 1'b1, 1'b1);
    i_init = 1'b1; i_load = 1'b1; i_load_value = 8'd5; i_enable = 1'b1;
    cycle();
    i_init = 1'b0; i_load = 1'b0; i_enable = 1'b0;
    outs("init_over_load", 8'd0, 1'b0, 1'b0, 1'b0);

    // Load beats a simultaneous advance
    i_inc_dec = 1'b1;
    i_load = 1'b1; i_load_value = 8'd3; i_enable = 1'b1;
    cycle();
    i_load = 1'b0; i_enable = 1'b0;
    outs("load_over_adv", 8'd3, 1'b0, 1'b0, 1'b0);

    // Out-of-range load then an up advance clamps to limit
    load(8'hF0);
    check("oor_load", o_value, 8'hF0);
    advance();
    outs("oor_adv", 8'd9, 1'b1, 1'b1, 1'b0);

    // Async reset mid-cycle with value 0x37 and both flags set
    load(8'd0);
    i_inc_dec = 1'b0;
    advance();
    load(8'h37);
    outs("pre_reset", 8'h37, 1'b0, 1'b1, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    outs("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    outs("held_reset", 8'd0, 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    i_inc_dec = 1'b1; i_limit = 8'hFF;
    advance();
    outs("restart", 8'd1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
